// File: rtl/uart_pkg.sv
// Shared UART definitions: default timing and FIFO depth, plus the receive FSM state encoding.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_DEPTH        = 8;

    localparam logic [1:0] RX_IDLE_ENC  = 2'd0;
    localparam logic [1:0] RX_START_ENC = 2'd1;
    localparam logic [1:0] RX_DATA_ENC  = 2'd2;
    localparam logic [1:0] RX_STOP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE  = RX_IDLE_ENC,
        RX_START = RX_START_ENC,
        RX_DATA  = RX_DATA_ENC,
        RX_STOP  = RX_STOP_ENC
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead circular FIFO with occupancy counter; storage is cleared by the asynchronous reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_FULL);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_reg] <= wr_data;
                wr_ptr_reg      <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling deframer and show-ahead byte FIFO
// with sticky overrun / framing-error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = DEFAULT_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_uart_rx,
    input  logic                   i_rx_pop,
    input  logic                   i_clear_err,
    output logic [7:0]             o_rx_data,
    output logic                   o_rx_valid,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overrun,
    output logic                   o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_t        state_reg;
    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             frame_err_reg;
    logic             overrun_reg;

    logic             rx_sync;
    logic             stop_sample;
    logic             push;
    logic             stop_bad;
    logic             overrun_set;
    logic             fifo_full;
    logic             fifo_empty;

    assign rx_sync     = sync_reg[1];
    assign stop_sample = (state_reg == RX_STOP) && (cnt_reg == LAST_CNT);
    assign push        = stop_sample && rx_sync;
    assign stop_bad    = stop_sample && !rx_sync;
    assign overrun_set = push && fifo_full && !i_rx_pop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_reg      <= 2'b11;
            state_reg     <= RX_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], i_uart_rx};

            case (state_reg)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_reg != HALF_CNT) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else if (!rx_sync) begin
                        state_reg   <= RX_DATA;
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                    end else begin
                        state_reg <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg != LAST_CNT) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else begin
                        shift_reg[bit_idx_reg] <= rx_sync;
                        cnt_reg                <= '0;
                        bit_idx_reg            <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (cnt_reg != LAST_CNT) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else begin
                        state_reg <= RX_IDLE;
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase

            if (stop_bad) begin
                frame_err_reg <= 1'b1;
            end else if (i_clear_err) begin
                frame_err_reg <= 1'b0;
            end

            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (i_clear_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (push),
        .pop     (i_rx_pop),
        .wr_data (shift_reg),
        .rd_data (o_rx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_count)
    );

    assign o_rx_valid  = !fifo_empty;
    assign o_overrun   = overrun_reg;
    assign o_frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized frames/pops, checked every cycle
// against a queue-based model of received bytes and sticky flags.
module tb_uart_rx_fifo;

    localparam int CPB      = 16;
    localparam int DEPTH    = 4;
    // Line driven low just after edge e: first capture at e+1, push at (e+1)+3+HALF+9*CPB.
    localparam int PUSH_LAT = 1 + 3 + (CPB - 1) / 2 + 9 * CPB;
    localparam int MAX_EV   = 256;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_uart_rx = 1'b1;
    logic       i_rx_pop = 1'b0;
    logic       i_clear_err = 1'b0;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic [2:0] o_count;
    logic       o_overrun;
    logic       o_frame_err;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_uart_rx   (i_uart_rx),
        .i_rx_pop    (i_rx_pop),
        .i_clear_err (i_clear_err),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_count     (o_count),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    // Frame completion events, written by the stimulus side only.
    int         ev_cyc  [MAX_EV];
    logic [7:0] ev_byte [MAX_EV];
    bit         ev_ok   [MAX_EV];
    int         ev_n = 0;

    // Behavioural model state, written by the model process only.
    int         edge_no = 0;
    int         ev_rd = 0;
    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    bit         mp_push, mp_bad, mp_drop;
    logic [7:0] mp_byte;

    always @(posedge i_clk) begin
        edge_no++;
        if (i_rst) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            ev_rd  = ev_n;
        end else begin
            mp_push = 1'b0;
            mp_bad  = 1'b0;
            mp_drop = 1'b0;
            mp_byte = 8'h00;
            if (ev_rd < ev_n && ev_cyc[ev_rd] == edge_no) begin
                if (ev_ok[ev_rd]) begin
                    mp_push = 1'b1;
                    mp_byte = ev_byte[ev_rd];
                end else begin
                    mp_bad = 1'b1;
                end
                ev_rd++;
            end
            if (i_rx_pop && mq.size() > 0) void'(mq.pop_front());
            if (mp_push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(mp_byte);
                    $display("edge %0d rx byte 0x%02h queued, depth %0d", edge_no, mp_byte, mq.size());
                end else begin
                    mp_drop = 1'b1;
                    $display("edge %0d rx byte 0x%02h dropped, queue full", edge_no, mp_byte);
                end
            end
            if (mp_bad) $display("edge %0d rx frame with bad stop bit", edge_no);
            if (mp_drop) m_ovr = 1'b1;
            else if (i_clear_err) m_ovr = 1'b0;
            if (mp_bad) m_ferr = 1'b1;
            else if (i_clear_err) m_ferr = 1'b0;
        end
    end

    int         checks = 0;
    int         errors = 0;
    bit         tx_busy = 1'b0;
    bit         rand_done = 1'b0;
    logic [7:0] d;
    logic [7:0] rb;
    bit         rok;
    logic [9:0] pf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        tx_busy = 1'b1;
        if (ev_n < MAX_EV) begin
            ev_cyc[ev_n]  = edge_no + PUSH_LAT;
            ev_byte[ev_n] = b;
            ev_ok[ev_n]   = stop;
            ev_n++;
        end
        for (int i = 0; i < 10; i++) begin
            i_uart_rx = f[i];
            idle(CPB);
        end
        i_uart_rx = 1'b1;
        tx_busy = 1'b0;
    endtask

    task automatic wait_tx();
        while (tx_busy) idle(1);
    endtask

    task automatic pop_one(output logic [7:0] v);
        v = o_rx_data;
        i_rx_pop = 1'b1;
        idle(1);
        i_rx_pop = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear_err = 1'b1;
        idle(1);
        i_clear_err = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge i_clk);
                if (i_rst) begin
                    chk("rst_valid", 32'(o_rx_valid), 32'd0);
                    chk("rst_count", 32'(o_count), 32'd0);
                    chk("rst_data", 32'(o_rx_data), 32'd0);
                    chk("rst_overrun", 32'(o_overrun), 32'd0);
                    chk("rst_frame_err", 32'(o_frame_err), 32'd0);
                end else begin
                    chk("valid", 32'(o_rx_valid), 32'(mq.size() != 0));
                    chk("count", 32'(o_count), 32'(mq.size()));
                    if (mq.size() != 0) chk("data", 32'(o_rx_data), 32'(mq[0]));
                    chk("overrun", 32'(o_overrun), 32'(m_ovr));
                    chk("frame_err", 32'(o_frame_err), 32'(m_ferr));
                end
            end
        join_none

        idle(3);
        i_rst = 1'b0;
        idle(5);

        // Single byte with exact push edge
        fork
            send_frame(8'hA5, 1'b1);
        join_none
        idle(PUSH_LAT - 1);
        chk("a5_valid_early", 32'(o_rx_valid), 32'd0);
        idle(1);
        chk("a5_valid", 32'(o_rx_valid), 32'd1);
        chk("a5_data", 32'(o_rx_data), 32'hA5);
        chk("a5_count", 32'(o_count), 32'd1);
        wait_tx();
        pop_one(d);
        chk("a5_pop_valid", 32'(o_rx_valid), 32'd0);
        chk("a5_pop_count", 32'(o_count), 32'd0);

        // Burst and overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(2);
        chk("burst_count", 32'(o_count), 32'd4);
        chk("burst_overrun", 32'(o_overrun), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            pop_one(d);
            chk("burst_pop_data", 32'(d), 32'(i));
        end
        chk("burst_empty", 32'(o_count), 32'd0);
        pulse_clear();
        chk("burst_overrun_clr", 32'(o_overrun), 32'd0);

        // Framing error, then a clean frame
        send_frame(8'h3C, 1'b0);
        idle(24);
        chk("ferr_flag", 32'(o_frame_err), 32'd1);
        chk("ferr_count", 32'(o_count), 32'd0);
        send_frame(8'h7E, 1'b1);
        idle(2);
        chk("ferr_next_data", 32'(o_rx_data), 32'h7E);
        chk("ferr_next_count", 32'(o_count), 32'd1);
        pop_one(d);
        pulse_clear();
        chk("ferr_clr", 32'(o_frame_err), 32'd0);

        // Glitch rejection
        i_uart_rx = 1'b0;
        idle(5);
        i_uart_rx = 1'b1;
        idle(30);
        chk("glitch_count", 32'(o_count), 32'd0);
        chk("glitch_overrun", 32'(o_overrun), 32'd0);
        chk("glitch_frame_err", 32'(o_frame_err), 32'd0);

        // Push and pop on the same edge while full
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h99, 1'b1);
        join_none
        idle(PUSH_LAT - 1);
        i_rx_pop = 1'b1;
        idle(1);
        i_rx_pop = 1'b0;
        chk("simul_count", 32'(o_count), 32'd4);
        chk("simul_overrun", 32'(o_overrun), 32'd0);
        wait_tx();
        pop_one(d); chk("simul_pop0", 32'(d), 32'h22);
        pop_one(d); chk("simul_pop1", 32'(d), 32'h33);
        pop_one(d); chk("simul_pop2", 32'(d), 32'h44);
        pop_one(d); chk("simul_pop3", 32'(d), 32'h99);
        pop_one(d);
        chk("empty_pop_count", 32'(o_count), 32'd0);
        chk("empty_pop_valid", 32'(o_rx_valid), 32'd0);

        // Reset in the middle of bit 3, with data and a flag pending
        send_frame(8'h81, 1'b1);
        send_frame(8'h42, 1'b0);
        idle(24);
        chk("prerst_count", 32'(o_count), 32'd1);
        chk("prerst_frame_err", 32'(o_frame_err), 32'd1);
        pf = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 4; i++) begin
            i_uart_rx = pf[i];
            idle(CPB);
        end
        i_uart_rx = pf[4];
        idle(8);
        i_rst = 1'b1;
        #1;
        chk("rst_now_count", 32'(o_count), 32'd0);
        chk("rst_now_valid", 32'(o_rx_valid), 32'd0);
        chk("rst_now_data", 32'(o_rx_data), 32'd0);
        chk("rst_now_frame_err", 32'(o_frame_err), 32'd0);
        i_uart_rx = 1'b1;
        idle(3);
        i_rst = 1'b0;
        idle(5);
        send_frame(8'h55, 1'b1);
        idle(2);
        chk("postrst_data", 32'(o_rx_data), 32'h55);
        chk("postrst_count", 32'(o_count), 32'd1);
        pop_one(d);

        // Randomized frames, glitches, pops and clears
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    if ($urandom_range(0, 99) < 10) begin
                        i_uart_rx = 1'b0;
                        idle($urandom_range(1, 7));
                        i_uart_rx = 1'b1;
                        idle(20);
                    end
                    rb  = 8'($urandom);
                    rok = ($urandom_range(0, 99) >= 15);
                    send_frame(rb, rok);
                    if (rok) idle($urandom_range(1, 12));
                    else idle(24 + $urandom_range(0, 10));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    i_rx_pop    = ($urandom_range(0, 149) == 0);
                    i_clear_err = ($urandom_range(0, 199) == 0);
                    idle(1);
                end
                i_rx_pop    = 1'b0;
                i_clear_err = 1'b0;
            end
        join

        idle(2);
        while (mq.size() > 0) pop_one(d);
        idle(2);
        chk("final_count", 32'(o_count), 32'd0);
        chk("final_valid", 32'(o_rx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
